// File: rtl/minifloat_divider.sv
// Minifloat divider: {sign, exponent, fraction} words, round-to-nearest-even,
// denormal support, restoring division at one quotient bit per cycle.
// Operands and result move over stb/ack handshakes; A is always taken before B.
module minifloat_divider #(
  parameter int N   = 8,
  parameter int EXP = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] input_a,
  input  logic         input_a_stb,
  output logic         input_a_ack,
  input  logic [N-1:0] input_b,
  input  logic         input_b_stb,
  output logic         input_b_ack,
  output logic [N-1:0] output_z,
  output logic         output_z_stb,
  input  logic         output_z_ack
);

  localparam int FRAC = N - 1 - EXP;
  localparam int BIAS = 2**(EXP-1) - 1;
  localparam int E_W  = EXP + 2;      // signed working exponent
  localparam int M_W  = FRAC + 1;     // mantissa with hidden bit
  localparam int Q_W  = FRAC + 4;     // mantissa + guard + round + extra
  localparam int R_W  = FRAC + 3;     // partial remainder
  localparam int C_W  = $clog2(Q_W + 1);

  localparam logic signed [E_W-1:0] E_BIAS = E_W'(BIAS);
  localparam logic signed [E_W-1:0] E_MIN  = E_W'(1 - BIAS);
  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
  localparam logic [C_W-1:0]        LAST   = C_W'(Q_W - 1);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_SETUP,
    DIV_LOOP, NORM_1, NORM_2, ROUND, PACK, PUT_Z
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]            a, b;
  logic [M_W-1:0]          a_m, b_m, z_m;
  logic signed [E_W-1:0]   a_e, b_e, z_e;
  logic                    z_s;
  logic [Q_W-1:0]          q;
  logic [R_W-1:0]          rem;
  logic [C_W-1:0]          cnt;
  logic                    sticky;
  logic [N-1:0]            z_out;

  // Operand classification straight from the captured raw words
  logic a_ones, b_ones, a_frac_nz, b_frac_nz;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic sp_nan, any_special;

  assign a_ones    = &a[N-2:FRAC];
  assign b_ones    = &b[N-2:FRAC];
  assign a_frac_nz = |a[FRAC-1:0];
  assign b_frac_nz = |b[FRAC-1:0];
  assign a_nan     = a_ones & a_frac_nz;
  assign b_nan     = b_ones & b_frac_nz;
  assign a_inf     = a_ones & ~a_frac_nz;
  assign b_inf     = b_ones & ~b_frac_nz;
  assign a_zero    = ~|a[N-2:0];
  assign b_zero    = ~|b[N-2:0];
  assign sp_nan    = a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero);
  assign any_special = sp_nan | a_inf | b_inf | b_zero | a_zero;

  // One restoring-division step
  logic [R_W-1:0] b_ext, div_diff, rem_next;
  logic           div_ge;

  assign b_ext    = {{(R_W-M_W){1'b0}}, b_m};
  assign div_ge   = rem >= b_ext;
  assign div_diff = div_ge ? (rem - b_ext) : rem;
  assign rem_next = div_diff << 1;

  // Rounding: guard=q[2], round=q[1], q[0] only matters as extra sticky
  logic           round_up;
  logic [M_W:0]   m_inc;
  logic [EXP-1:0] pack_exp;

  assign round_up = q[2] & (q[1] | q[0] | sticky | q[3]);
  assign m_inc    = {1'b0, q[Q_W-1 -: M_W]} + (M_W+1)'(1);
  assign pack_exp = EXP'(z_e + E_BIAS);

  assign output_z = z_out;

  // State register; reset wins over every transition
  always_ff @(posedge clk) begin
    if (rst) state <= GET_A;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt    = state;
    input_a_ack  = 1'b0;
    input_b_ack  = 1'b0;
    output_z_stb = 1'b0;
    case (state)
      GET_A: begin
        input_a_ack = 1'b1;
        if (input_a_stb) state_nxt = GET_B;
      end
      GET_B: begin
        input_b_ack = 1'b1;
        if (input_b_stb) state_nxt = UNPACK;
      end
      UNPACK:    state_nxt = SPECIAL;
      SPECIAL:   state_nxt = any_special ? PUT_Z : NORM_A;
      NORM_A:    if (a_m[M_W-1]) state_nxt = NORM_B;
      NORM_B:    if (b_m[M_W-1]) state_nxt = DIV_SETUP;
      DIV_SETUP: state_nxt = DIV_LOOP;
      DIV_LOOP:  if (cnt == LAST) state_nxt = NORM_1;
      NORM_1:    if (q[Q_W-1]) state_nxt = NORM_2;
      NORM_2:    if (!(z_e < E_MIN)) state_nxt = ROUND;
      ROUND:     state_nxt = PACK;
      PACK:      state_nxt = PUT_Z;
      PUT_Z: begin
        output_z_stb = 1'b1;
        if (output_z_ack) state_nxt = GET_A;
      end
      default:   state_nxt = GET_A;
    endcase
  end

  // Datapath: each state updates only the registers it owns
  always_ff @(posedge clk) begin
    if (rst) begin
      z_out <= '0;
    end else begin
      case (state)
        GET_A: if (input_a_stb) a <= input_a;
        GET_B: if (input_b_stb) b <= input_b;
        UNPACK: begin
          a_m <= {|a[N-2:FRAC], a[FRAC-1:0]};
          b_m <= {|b[N-2:FRAC], b[FRAC-1:0]};
          a_e <= (a[N-2:FRAC] == '0) ? E_MIN
                 : $signed({{(E_W-EXP){1'b0}}, a[N-2:FRAC]}) - E_BIAS;
          b_e <= (b[N-2:FRAC] == '0) ? E_MIN
                 : $signed({{(E_W-EXP){1'b0}}, b[N-2:FRAC]}) - E_BIAS;
        end
        SPECIAL: begin
          if (sp_nan)
            z_out <= {1'b1, {EXP{1'b1}}, 1'b1, {(FRAC-1){1'b0}}};
          else if (a_inf)
            z_out <= {a[N-1] ^ b[N-1], {EXP{1'b1}}, {FRAC{1'b0}}};
          else if (b_inf)
            z_out <= {a[N-1] ^ b[N-1], {(N-1){1'b0}}};
          else if (b_zero)
            z_out <= {a[N-1] ^ b[N-1], {EXP{1'b1}}, {FRAC{1'b0}}};
          else if (a_zero)
            z_out <= {a[N-1] ^ b[N-1], {(N-1){1'b0}}};
        end
        NORM_A: if (!a_m[M_W-1]) begin
          a_m <= a_m << 1;
          a_e <= a_e - E_ONE;
        end
        NORM_B: if (!b_m[M_W-1]) begin
          b_m <= b_m << 1;
          b_e <= b_e - E_ONE;
        end
        DIV_SETUP: begin
          z_s    <= a[N-1] ^ b[N-1];
          z_e    <= a_e - b_e;
          q      <= '0;
          cnt    <= '0;
          rem    <= {{(R_W-M_W){1'b0}}, a_m};
          sticky <= 1'b0;
        end
        DIV_LOOP: begin
          q      <= {q[Q_W-2:0], div_ge};
          rem    <= rem_next;
          cnt    <= cnt + C_W'(1);
          sticky <= |rem_next;   // last iteration leaves the final remainder flag
        end
        NORM_1: if (!q[Q_W-1]) begin
          q   <= q << 1;
          z_e <= z_e - E_ONE;
        end
        NORM_2: if (z_e < E_MIN) begin
          q      <= q >> 1;
          z_e    <= z_e + E_ONE;
          sticky <= sticky | q[0];
        end
        ROUND: begin
          if (round_up && m_inc[M_W]) begin
            z_m <= {1'b1, {FRAC{1'b0}}};
            z_e <= z_e + E_ONE;
          end else if (round_up) begin
            z_m <= m_inc[M_W-1:0];
          end else begin
            z_m <= q[Q_W-1 -: M_W];
          end
        end
        PACK: begin
          if (z_e > E_BIAS)
            z_out <= {z_s, {EXP{1'b1}}, {FRAC{1'b0}}};
          else if (!z_m[M_W-1])
            z_out <= {z_s, {EXP{1'b0}}, z_m[FRAC-1:0]};
          else
            z_out <= {z_s, pack_exp, z_m[FRAC-1:0]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/minifloat_divider.md
MINIFLOAT_DIVIDER -- requirements
Module: minifloat_divider

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning total word width.
REQ-002 The block SHALL have parameter EXP, default 3, meaning exponent field width; FRAC = N-1-EXP (default 4); bias = 2^(EXP-1)-1 (default 3).
REQ-003 The block SHALL have port clk, input, 1, clock, with all state changing on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port input_a, input, N, dividend as {sign, exponent, fraction}.
REQ-006 The block SHALL have ports input_a_stb (input, 1, dividend valid) and input_a_ack (output, 1, dividend ready).
REQ-007 The block SHALL have port input_b, input, N, divisor, same format as input_a.
REQ-008 The block SHALL have ports input_b_stb (input, 1, divisor valid) and input_b_ack (output, 1, divisor ready).
REQ-009 The block SHALL have ports output_z (output, N, quotient) and output_z_stb (output, 1, quotient valid).
REQ-010 The block SHALL have port output_z_ack, input, 1, meaning the consumer accepts the quotient.

Function
REQ-011 Each port SHALL transfer a word on a rising edge where its stb and ack are both high; the ack SHALL be low in the cycle after the transfer.
REQ-012 The FSM SHALL have states GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_SETUP, DIV_LOOP, NORM_1, NORM_2, ROUND, PACK and PUT_Z.
REQ-013 input_a_ack SHALL be high only in GET_A, and input_b_ack SHALL be high only in GET_B; B SHALL be accepted only after A.
REQ-014 UNPACK: an exponent field of 0 SHALL be treated as a denormal, with exponent 1-bias and hidden bit 0; otherwise the exponent SHALL be field-bias and the hidden bit 1; the exponent register SHALL be EXP+2 bits signed.
REQ-015 SPECIAL SHALL resolve the following cases in priority order, each going directly to PUT_Z.
REQ-016 Special case 1: if either operand is NaN, or both are inf, or both are zero, z SHALL be canonical NaN {1, all-ones exponent, 1, zeros}.
REQ-017 Special case 2: if a is inf, z SHALL be inf with sign a_s^b_s.
REQ-018 Special case 3: if b is inf, z SHALL be signed zero.
REQ-019 Special case 4: if b is zero, z SHALL be signed inf.
REQ-020 Special case 5: if a is zero, z SHALL be signed zero.
REQ-021 When no special case applies, the FSM SHALL go to NORM_A.
REQ-022 NORM_A and NORM_B SHALL left-shift a denormal mantissa one bit per cycle, decrementing the exponent, until the hidden bit is 1.
REQ-023 DIV_SETUP SHALL set z_s = a_s^b_s and z_e = a_e-b_e, and SHALL clear the quotient and loop counter.
REQ-024 DIV_LOOP SHALL perform restoring division at 1 quotient bit per cycle for FRAC+4 cycles, producing the mantissa, guard, round and an extra bit; sticky SHALL be set when the final remainder is nonzero.
REQ-025 NORM_1 SHALL left-shift while the quotient MSB is 0, decrementing z_e once per shift; at most one shift SHALL occur for normal operands.
REQ-026 NORM_2 SHALL right-shift while z_e < 1-bias, incrementing z_e, with shifted-out bits OR'd into sticky, so that the result is denormalised.
REQ-027 ROUND SHALL use round-to-nearest-even: the mantissa SHALL be incremented when guard && (round|sticky|lsb); mantissa overflow SHALL increment z_e and reset the mantissa to the hidden-bit value.
REQ-028 PACK: z_e > bias SHALL produce signed inf; a hidden bit of 0 SHALL produce exponent field 0; otherwise the exponent field SHALL be z_e+bias.
REQ-029 PUT_Z SHALL hold output_z_stb high with output_z stable until output_z_ack is sampled high, then SHALL drop stb and return to GET_A.
REQ-030 Latency from B accept to output_z_stb SHALL be variable, and SHALL NOT exceed FRAC+2*N+12 cycles.
REQ-031 Input stb asserted in any other state SHALL be ignored, and the input words SHALL NOT be sampled.

Reset
REQ-032 When rst is high at a clock edge, the state SHALL become GET_A and output_z_stb, input_b_ack and output_z SHALL become 0; input_a_ack SHALL be high in the next cycle.
REQ-033 Reset SHALL take priority over every FSM transition; reset mid-operation SHALL discard the in-flight division with no output strobe.
REQ-034 With rst held high, no ack or stb output SHALL assert other than input_a_ack.

Verification (defaults N=8, EXP=3)
REQ-035 Bench SHALL check: a=0x58 (6.0), b=0x40 (2.0) -> output_z=0x48 (3.0), with output_z_stb held until ack.
REQ-036 Bench SHALL check: a=0xC8 (-3.0), b=0x40 -> output_z=0xB8 (-1.5); and a=0x30, b=0x48 (1/3) -> output_z=0x15.
REQ-037 Bench SHALL check: a=0x30, b=0x00 -> output_z=0x70; a=0x00, b=0x00 -> 0xF8; a=0x70, b=0x70 -> 0xF8; a=0x30, b=0x70 -> 0x00.
REQ-038 Bench SHALL check: a=0x6F (15.5), b=0x20 (0.5) -> output_z=0x70 (overflow to inf); a=0x01 (denormal 2^-6), b=0x30 -> 0x01.
REQ-039 Bench SHALL check: output_z_ack held low for 10 cycles -> output_z_stb and output_z remain stable and input_a_ack stays low; ack high for 1 cycle -> stb low next cycle.
REQ-040 Bench SHALL check: rst asserted during DIV_LOOP -> no output_z_stb; the next operand pair a=0x40, b=0x30 -> output_z=0x40.
